// File: rtl/conv_pkg.sv
//------------------------------------------------------------------------------
// Module : conv_pkg
// Brief  : Shared geometry, word-packing constants and writer FSM encoding.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package conv_pkg;

    localparam int IMG_W          = 640;
    localparam int IMG_H          = 480;
    localparam int PIX_W          = 4;
    localparam int PIX_PER_WORD   = 3;
    localparam int WORDS_PER_LINE = 214;
    localparam int ADDR_W         = 17;
    localparam int SUM_W          = 12;
    localparam int WORD_W         = PIX_W * PIX_PER_WORD;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PACK = 2'd1,
        DONE = 2'd2
    } wr_state_e;

endpackage

`default_nettype wire

// File: rtl/pixel_quantizer.sv
//------------------------------------------------------------------------------
// Module : pixel_quantizer
// Brief  : Combinational scale + clamp of a signed convolution sum to one pixel.
//          Macro WRITER_ABS_EN: take |q| before clamping (edge magnitude).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pixel_quantizer
    import conv_pkg::*;
#(
    parameter int RES_SHIFT = 4
) (
    input  logic signed [SUM_W-1:0] conv_sum,
    output logic        [PIX_W-1:0] pix
);

    logic signed [SUM_W-1:0] q;
    logic signed [SUM_W-1:0] mag;

    always_comb begin
        q = conv_sum >>> RES_SHIFT;
`ifdef WRITER_ABS_EN
        mag = q[SUM_W-1] ? -q : q;
`else
        mag = q;
`endif
        if (mag[SUM_W-1]) begin
            pix = '0;
        end else if (|mag[SUM_W-2:PIX_W]) begin
            pix = '1;
        end else begin
            pix = mag[PIX_W-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/conv_result_writer.sv
//------------------------------------------------------------------------------
// Module : conv_result_writer
// Brief  : Quantizes raster-order conv sums, packs 3 pixels/word, writes BRAM.
//          Macro WRITER_ABS_EN selects magnitude quantization (see pixel_quantizer).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module conv_result_writer #(
    parameter int IMG_W     = conv_pkg::IMG_W,
    parameter int IMG_H     = conv_pkg::IMG_H,
    parameter int RES_SHIFT = 4,
    parameter int BASE_ADDR = 0
) (
    input  logic                        pixel_clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        in_valid,
    input  logic [conv_pkg::SUM_W-1:0]  conv_sum,
    output logic                        in_ready,
    output logic                        bram_we,
    output logic [conv_pkg::ADDR_W-1:0] bram_addr,
    output logic [conv_pkg::WORD_W-1:0] bram_din,
    output logic                        done
);

    import conv_pkg::*;

    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int LINE_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    wr_state_e          state_q, state_d;
    logic [1:0]         slot_q, slot_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [WORD_W-1:0]  acc_q, acc_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [WORD_W-1:0]  din_q, din_d;
    logic               done_q, done_d;

    logic [PIX_W-1:0]   pix_w;
    logic [WORD_W-1:0]  word_w;
    logic               ready_w;
    logic               xfer_w;
    logic               last_col_w;
    logic               last_line_w;

    pixel_quantizer #(
        .RES_SHIFT (RES_SHIFT)
    ) u_quant (
        .conv_sum  (conv_sum),
        .pix       (pix_w)
    );

    assign ready_w     = (state_q == PACK) && enable;
    assign xfer_w      = in_valid && ready_w;
    assign last_col_w  = (col_q == COL_W'(IMG_W - 1));
    assign last_line_w = (line_q == LINE_W'(IMG_H - 1));

    // Drop the new pixel into its nibble; the accumulator is cleared after every write,
    // so nibbles beyond a short line-end word stay zero.
    always_comb begin
        word_w = acc_q;
        case (slot_q)
            2'd0:    word_w[11:8] = pix_w;
            2'd1:    word_w[7:4]  = pix_w;
            default: word_w[3:0]  = pix_w;
        endcase
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        col_d   = col_q;
        line_d  = line_q;
        acc_d   = acc_q;
        waddr_d = waddr_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        done_d  = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = PACK;
                    slot_d  = 2'd0;
                    col_d   = '0;
                    line_d  = '0;
                    acc_d   = '0;
                    waddr_d = ADDR_W'(BASE_ADDR);
                end
            end
            PACK: begin
                if (xfer_w) begin
                    acc_d  = word_w;
                    slot_d = slot_q + 2'd1;
                    if ((slot_q == 2'd2) || last_col_w) begin
                        we_d    = 1'b1;
                        addr_d  = waddr_q;
                        din_d   = word_w;
                        waddr_d = waddr_q + ADDR_W'(1);
                        acc_d   = '0;
                        slot_d  = 2'd0;
                    end
                    if (last_col_w) begin
                        col_d = '0;
                        if (last_line_w) begin
                            line_d  = '0;
                            waddr_d = ADDR_W'(BASE_ADDR);
                            state_d = DONE;
                        end else begin
                            line_d = line_q + LINE_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            slot_q  <= 2'd0;
            col_q   <= '0;
            line_q  <= '0;
            acc_q   <= '0;
            waddr_q <= ADDR_W'(BASE_ADDR);
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            col_q   <= col_d;
            line_q  <= line_d;
            acc_q   <= acc_d;
            waddr_q <= waddr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            done_q  <= done_d;
        end
    end

    assign in_ready  = ready_w;
    assign bram_we   = we_q;
    assign bram_addr = addr_q;
    assign bram_din  = din_q;
    assign done      = done_q;

endmodule

`default_nettype wire
